fc_state_rx_mc: RTL and testbench
=================================

FC_STATE_RX_MC -- requirements
Module: fc_state_rx_mc

Interface
REQ-001 Parameter NUM_CH, 2, number of independent FC receive lanes (1..8).
REQ-002 Parameter OL1_DELAY, 531250, minimum OL1 dwell in clk cycles (5 ms @ 106.25 MHz); must be >= 1.
REQ-003 Parameter IDLE_MIN, 6, number of cycles in AC before is_active asserts; must be >= 1.
REQ-004 Parameter LOS_CYCLES, 1024, number of consecutive cycles with rx_sync low that forces link failure; must be >= 1.
REQ-005 clk  input  1  clock; all logic is on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 data  input  32*NUM_CH  received word per lane; lane i is bits [32i+31:32i].
REQ-008 datak  input  4*NUM_CH  K-flags per lane; lane i is bits [4i+3:4i].
REQ-009 rx_sync  input  NUM_CH  per-lane word sync from the PCS.
REQ-010 online  input  NUM_CH  per-lane permission to leave OL1.
REQ-011 cnt_clear  input  NUM_CH  per-lane synchronous clear of fail_cnt.
REQ-012 state  output  NUM_CH x fc::state_t  current port state per lane.
REQ-013 is_active  output  NUM_CH  lane has been in AC for at least IDLE_MIN cycles.
REQ-014 state_chg  output  NUM_CH  one-cycle pulse when the lane state register changes.
REQ-015 fail_cnt  output  16*NUM_CH  per-lane saturating count of entries into LF1 or LF2.

Function
REQ-016 Lanes are fully independent; no signal of lane i affects lane j.
REQ-017 A lane word is a valid primitive only when its datak == 4'b1000 and its rx_sync == 1; the primitive is decoded with fc::map_primitive.
REQ-018 On a valid primitive, next state follows this table; all other cases hold the state:
- OLS: OL1->OL2 only if online=1 and ol1_cnt=0; any other state ->OL2.
- NOS: any state ->LF1.
- LR: OL3 or LF2 ->LF2; else ->LR2.
- LRR: LF1->LF1, LF2->LF2, OL1->OL1, OL3->LF2; else ->LR3.
- IDLE or ARBff: LR2->AC, LR3->AC, OL3->OL2; else hold.
REQ-019 The state register updates one cycle after the primitive is presented (latency 1).
REQ-020 ol1_cnt is loaded with OL1_DELAY while the lane is not in OL1 and on reset; in OL1 it decrements by 1 per cycle and stops at 0.
REQ-021 online is registered per lane; a 0->1 edge of registered online while the state is not OL1 forces OL1 on the next cycle.
REQ-022 los_cnt counts consecutive cycles with rx_sync=0 and clears when rx_sync=1; it saturates at LOS_CYCLES.
REQ-023 When los_cnt reaches LOS_CYCLES and the state is not OL1 and not LF2, the lane enters LF2 on the next cycle. Re-entry to LF2 from LF2 does not occur.
REQ-024 Priority per lane is reset > online edge (REQ-021) > LOS (REQ-023) > primitive table.
REQ-025 The hold-off counter is IDLE_MIN while the state is not AC and decrements to 0 while in AC; is_active = (counter == 0). is_active rises IDLE_MIN cycles after state first reads AC and falls on the cycle state leaves AC.
REQ-026 state_chg = 1 on exactly the cycle when state differs from its value on the previous cycle.
REQ-027 fail_cnt increments by 1 on each transition into LF1 or LF2 from a different state and saturates at 16'hFFFF. cnt_clear sets it to 0 and overrides a same-cycle increment.

Reset
REQ-028 While reset is high, every lane goes to state OL1, ol1_cnt=OL1_DELAY, los_cnt=0, hold-off=IDLE_MIN, registered online=0, and fail_cnt=0.
REQ-029 During reset and on the first cycle after reset, is_active=0 and state_chg=0.
REQ-030 Reset applied mid-operation, including while in AC, gives the same state as REQ-028 on the next cycle.

Verification (NUM_CH=2, OL1_DELAY=8, IDLE_MIN=6, LOS_CYCLES=4)
REQ-031 Lane0 online=1, continuous OLS after reset -> stays OL1 for 8 cycles, then OL2; state_chg pulses once; lane1 stays OL1.
REQ-032 Lane0 in OL2: LR then IDLE -> LR2 then AC; is_active rises 6 cycles after AC; a NOS then gives LF1, is_active=0 next cycle, fail_cnt=1.
REQ-033 Lane0 in AC: rx_sync=0 for 4 cycles -> LF2 on the 5th cycle; fail_cnt increments once; primitives during rx_sync=0 are ignored.
REQ-034 Lane1 in AC: online toggled 0->1 while LRR is presented -> OL1 wins; ol1_cnt reloads to 8.
REQ-035 Valid primitive with datak=4'b0001 or 4'b0000 -> no state change on either lane.
REQ-036 fail_cnt preset near 16'hFFFF by forcing NOS/OLS cycles -> holds at 16'hFFFF; cnt_clear asserted with a same-cycle LF entry -> reads 0.

Source files
------------

// File: rtl/fc_state_rx_mc.sv
// Multi-lane Fibre Channel port-state receiver. Each lane decodes its incoming primitives and
// tracks its link state, activity hold-off, loss-of-sync timer and failure count on its own.

package fc;

  typedef enum logic [3:0] {
    StOl1, StOl2, StOl3, StLr1, StLr2, StLr3, StLf1, StLf2, StAc
  } state_t;

  typedef enum logic [2:0] {
    PrimNone, PrimIdle, PrimArbff, PrimOls, PrimNos, PrimLr, PrimLrr
  } prim_t;

  // Ordered sets are K28.5 in the top byte followed by three data characters.
  function automatic prim_t map_primitive(input logic [31:0] word);
    prim_t prim;
    case (word)
      32'hBC95_B5B5: prim = PrimIdle;
      32'hBC94_FFFF: prim = PrimArbff;
      32'hBC35_8A55: prim = PrimOls;
      32'hBC55_BF45: prim = PrimNos;
      32'hBC49_BF49: prim = PrimLr;
      32'hBC35_BF49: prim = PrimLrr;
      default:       prim = PrimNone;
    endcase
    return prim;
  endfunction

endpackage

module fc_state_rx_mc #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned OL1_DELAY  = 531250,
  parameter int unsigned IDLE_MIN   = 6,
  parameter int unsigned LOS_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [32*NUM_CH-1:0]     data,
  input  logic [4*NUM_CH-1:0]      datak,
  input  logic [NUM_CH-1:0]        rx_sync,
  input  logic [NUM_CH-1:0]        online,
  input  logic [NUM_CH-1:0]        cnt_clear,
  output fc::state_t [NUM_CH-1:0]  state,
  output logic [NUM_CH-1:0]        is_active,
  output logic [NUM_CH-1:0]        state_chg,
  output logic [16*NUM_CH-1:0]     fail_cnt
);

  localparam int unsigned OlW   = $clog2(OL1_DELAY + 1);
  localparam int unsigned LosW  = $clog2(LOS_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(IDLE_MIN + 1);

  localparam logic [OlW-1:0]   Ol1Load  = OlW'(OL1_DELAY);
  localparam logic [LosW-1:0]  LosMax   = LosW'(LOS_CYCLES);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(IDLE_MIN);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    fc::state_t       state_q, state_d, prev_q, table_state;
    fc::prim_t        prim;
    logic [OlW-1:0]   ol1_cnt_q, ol1_cnt_d;
    logic [LosW-1:0]  los_cnt_q, los_cnt_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [15:0]      fail_cnt_q, fail_cnt_d;
    logic             online_q;
    logic             prim_valid, online_rise, los_trip, lf_entry;

    assign prim_valid  = (datak[4*ch +: 4] == 4'b1000) && rx_sync[ch];
    assign prim        = prim_valid ? fc::map_primitive(data[32*ch +: 32]) : fc::PrimNone;
    assign online_rise = online[ch] && !online_q && (state_q != fc::StOl1);
    assign los_trip    = (los_cnt_q == LosMax) && (state_q != fc::StOl1) &&
                         (state_q != fc::StLf2);

    always_comb begin
      table_state = state_q;
      case (prim)
        fc::PrimOls: begin
          if (state_q != fc::StOl1) begin
            table_state = fc::StOl2;
          end else if (online_q && (ol1_cnt_q == '0)) begin
            table_state = fc::StOl2;
          end
        end
        fc::PrimNos: table_state = fc::StLf1;
        fc::PrimLr: begin
          if ((state_q == fc::StOl3) || (state_q == fc::StLf2)) table_state = fc::StLf2;
          else                                                  table_state = fc::StLr2;
        end
        fc::PrimLrr: begin
          case (state_q)
            fc::StLf1, fc::StLf2, fc::StOl1: table_state = state_q;
            fc::StOl3:                       table_state = fc::StLf2;
            default:                         table_state = fc::StLr3;
          endcase
        end
        fc::PrimIdle, fc::PrimArbff: begin
          case (state_q)
            fc::StLr2, fc::StLr3: table_state = fc::StAc;
            fc::StOl3:            table_state = fc::StOl2;
            default:              table_state = state_q;
          endcase
        end
        default: table_state = state_q;
      endcase
    end

    always_comb begin
      state_d    = table_state;
      ol1_cnt_d  = Ol1Load;
      los_cnt_d  = '0;
      hold_d     = HoldLoad;
      fail_cnt_d = fail_cnt_q;

      if (online_rise) begin
        state_d = fc::StOl1;
      end else if (los_trip) begin
        state_d = fc::StLf2;
      end

      if ((state_q == fc::StOl1) && (ol1_cnt_q != '0)) ol1_cnt_d = ol1_cnt_q - 1'b1;
      else if (state_q == fc::StOl1)                    ol1_cnt_d = '0;

      if (!rx_sync[ch]) los_cnt_d = (los_cnt_q == LosMax) ? los_cnt_q : los_cnt_q + 1'b1;

      if ((state_q == fc::StAc) && (hold_q != '0)) hold_d = hold_q - 1'b1;
      else if (state_q == fc::StAc)                 hold_d = '0;

      lf_entry = ((state_d == fc::StLf1) || (state_d == fc::StLf2)) && (state_d != state_q);
      // Clear wins over a same-cycle failure entry.
      if (cnt_clear[ch]) begin
        fail_cnt_d = '0;
      end else if (lf_entry && (fail_cnt_q != 16'hFFFF)) begin
        fail_cnt_d = fail_cnt_q + 16'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q    <= fc::StOl1;
        prev_q     <= fc::StOl1;
        ol1_cnt_q  <= Ol1Load;
        los_cnt_q  <= '0;
        hold_q     <= HoldLoad;
        online_q   <= 1'b0;
        fail_cnt_q <= '0;
      end else begin
        state_q    <= state_d;
        prev_q     <= state_q;
        ol1_cnt_q  <= ol1_cnt_d;
        los_cnt_q  <= los_cnt_d;
        hold_q     <= hold_d;
        online_q   <= online[ch];
        fail_cnt_q <= fail_cnt_d;
      end
    end

    assign state[ch]             = state_q;
    assign is_active[ch]         = !reset && (state_q == fc::StAc) && (hold_q == '0);
    assign state_chg[ch]         = !reset && (state_q != prev_q);
    assign fail_cnt[16*ch +: 16] = fail_cnt_q;
  end

endmodule

// File: tb/tb_fc_state_rx_mc.sv
// Directed bench for fc_state_rx_mc with two lanes and short timers
// (OL1_DELAY=8, IDLE_MIN=6, LOS_CYCLES=4).

module tb_fc_state_rx_mc;

  localparam logic [31:0] WIdle = 32'hBC95_B5B5;
  localparam logic [31:0] WOls  = 32'hBC35_8A55;
  localparam logic [31:0] WNos  = 32'hBC55_BF45;
  localparam logic [31:0] WLr   = 32'hBC49_BF49;
  localparam logic [31:0] WLrr  = 32'hBC35_BF49;
  localparam logic [3:0]  KOk   = 4'b1000;

  logic            clk = 1'b0;
  logic            reset;
  logic [63:0]     data;
  logic [7:0]      datak;
  logic [1:0]      rx_sync, online, cnt_clear;
  fc::state_t [1:0] state;
  logic [1:0]      is_active, state_chg;
  logic [31:0]     fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fc_state_rx_mc #(
    .NUM_CH    (2),
    .OL1_DELAY (8),
    .IDLE_MIN  (6),
    .LOS_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .datak    (datak),
    .rx_sync  (rx_sync),
    .online   (online),
    .cnt_clear(cnt_clear),
    .state    (state),
    .is_active(is_active),
    .state_chg(state_chg),
    .fail_cnt (fail_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int lane, input logic [31:0] w, input logic [3:0] k);
    data[32*lane +: 32] = w;
    datak[4*lane +: 4]  = k;
  endtask

  task automatic test_reset();
    reset = 1'b1; online = '0; cnt_clear = '0; rx_sync = 2'b11; data = '0; datak = '0;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (state[i] !== fc::StOl1) begin
        n_fail++; $display("FAIL reset_state lane%0d got=%0d want=%0d", i, state[i], fc::StOl1);
      end
      n_checks++;
      if (is_active[i] !== 1'b0 || state_chg[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_flags lane%0d act=%b chg=%b want 0/0", i,
                           is_active[i], state_chg[i]);
      end
      n_checks++;
      if (fail_cnt[16*i +: 16] !== 16'd0) begin
        n_fail++; $display("FAIL reset_fail_cnt lane%0d got=%h want=0", i, fail_cnt[16*i +: 16]);
      end
    end
  endtask

  task automatic test_ols_exit();
    drive(0, WOls, KOk); online[0] = 1'b1; reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (state[0] !== fc::StOl1 || state_chg[0] !== 1'b0 || is_active[0] !== 1'b0) begin
        n_fail++; $display("FAIL ol1_dwell cyc%0d state=%0d chg=%b act=%b want OL1/0/0", k,
                           state[0], state_chg[0], is_active[0]);
      end
    end
    tick();
    n_checks++;
    if (state[0] !== fc::StOl2 || state_chg[0] !== 1'b1) begin
      n_fail++; $display("FAIL ol1_exit state=%0d chg=%b want=%0d/1", state[0], state_chg[0],
                         fc::StOl2);
    end
    tick();
    n_checks++;
    if (state[0] !== fc::StOl2 || state_chg[0] !== 1'b0) begin
      n_fail++; $display("FAIL ol2_hold state=%0d chg=%b want=%0d/0", state[0], state_chg[0],
                         fc::StOl2);
    end
    n_checks++;
    if (state[1] !== fc::StOl1 || state_chg[1] !== 1'b0) begin
      n_fail++; $display("FAIL lane1_idle state=%0d chg=%b want=%0d/0", state[1], state_chg[1],
                         fc::StOl1);
    end
  endtask

  task automatic test_active();
    drive(0, WLr, KOk); tick();
    n_checks++;
    if (state[0] !== fc::StLr2 || state_chg[0] !== 1'b1) begin
      n_fail++; $display("FAIL lr_to_lr2 state=%0d chg=%b want=%0d/1", state[0], state_chg[0],
                         fc::StLr2);
    end
    drive(0, WIdle, KOk); tick();
    n_checks++;
    if (state[0] !== fc::StAc || is_active[0] !== 1'b0) begin
      n_fail++; $display("FAIL idle_to_ac state=%0d act=%b want=%0d/0", state[0], is_active[0],
                         fc::StAc);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++;
      if (is_active[0] !== 1'b0) begin
        n_fail++; $display("FAIL holdoff cyc%0d act=%b want=0", k, is_active[0]);
      end
    end
    tick();
    n_checks++;
    if (is_active[0] !== 1'b1) begin
      n_fail++; $display("FAIL active_rise act=%b want=1", is_active[0]);
    end
    drive(0, WNos, KOk); tick();
    n_checks++;
    if (state[0] !== fc::StLf1 || is_active[0] !== 1'b0 || fail_cnt[15:0] !== 16'd1) begin
      n_fail++; $display("FAIL nos_to_lf1 state=%0d act=%b cnt=%h want=%0d/0/0001", state[0],
                         is_active[0], fail_cnt[15:0], fc::StLf1);
    end
    drive(0, WLr, KOk); tick();
    drive(0, WIdle, KOk); tick();
    n_checks++;
    if (state[0] !== fc::StAc) begin
      n_fail++; $display("FAIL back_to_ac state=%0d want=%0d", state[0], fc::StAc);
    end
  endtask

  task automatic test_los();
    rx_sync[0] = 1'b0; drive(0, WNos, KOk);
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++;
      if (state[0] !== fc::StAc) begin
        n_fail++; $display("FAIL los_wait cyc%0d state=%0d want=%0d", k, state[0], fc::StAc);
      end
    end
    rx_sync[0] = 1'b1; drive(0, WIdle, KOk);
    tick();
    n_checks++;
    if (state[0] !== fc::StLf2 || fail_cnt[15:0] !== 16'd2 || state_chg[0] !== 1'b1) begin
      n_fail++; $display("FAIL los_to_lf2 state=%0d cnt=%h chg=%b want=%0d/0002/1", state[0],
                         fail_cnt[15:0], state_chg[0], fc::StLf2);
    end
    tick();
    n_checks++;
    if (state[0] !== fc::StLf2 || fail_cnt[15:0] !== 16'd2) begin
      n_fail++; $display("FAIL lf2_hold state=%0d cnt=%h want=%0d/0002", state[0],
                         fail_cnt[15:0], fc::StLf2);
    end
  endtask

  task automatic test_online_edge();
    drive(1, WNos, KOk); tick();
    n_checks++;
    if (state[1] !== fc::StLf1 || fail_cnt[31:16] !== 16'd1) begin
      n_fail++; $display("FAIL lane1_lf1 state=%0d cnt=%h want=%0d/0001", state[1],
                         fail_cnt[31:16], fc::StLf1);
    end
    drive(1, WLr, KOk); tick();
    drive(1, WIdle, KOk); tick();
    n_checks++;
    if (state[1] !== fc::StAc) begin
      n_fail++; $display("FAIL lane1_ac state=%0d want=%0d", state[1], fc::StAc);
    end
    drive(1, WLrr, KOk); online[1] = 1'b1; tick();
    n_checks++;
    if (state[1] !== fc::StOl1 || state_chg[1] !== 1'b1) begin
      n_fail++; $display("FAIL online_wins state=%0d chg=%b want=%0d/1", state[1], state_chg[1],
                         fc::StOl1);
    end
    drive(1, WOls, KOk);
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (state[1] !== fc::StOl1) begin
        n_fail++; $display("FAIL ol1_reload cyc%0d state=%0d want=%0d", k, state[1], fc::StOl1);
      end
    end
    tick();
    n_checks++;
    if (state[1] !== fc::StOl2) begin
      n_fail++; $display("FAIL ol1_reload_exit state=%0d want=%0d", state[1], fc::StOl2);
    end
    n_checks++;
    if (state[0] !== fc::StLf2) begin
      n_fail++; $display("FAIL lane0_isolated state=%0d want=%0d", state[0], fc::StLf2);
    end
  endtask

  task automatic test_bad_k();
    logic [3:0] ks [2];
    ks[0] = 4'b0001; ks[1] = 4'b0000;
    for (int j = 0; j < 2; j++) begin
      drive(0, WNos, ks[j]); drive(1, WNos, ks[j]);
      repeat (2) tick();
      n_checks++;
      if (state[0] !== fc::StLf2 || state[1] !== fc::StOl2 || state_chg !== 2'b00) begin
        n_fail++; $display("FAIL bad_k k=%b s0=%0d s1=%0d chg=%b want %0d/%0d/00", ks[j],
                           state[0], state[1], state_chg, fc::StLf2, fc::StOl2);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(0, WNos, KOk); tick();
    drive(0, WLr, KOk); tick();
    drive(0, WIdle, KOk); tick();
    repeat (6) tick();
    n_checks++;
    if (state[0] !== fc::StAc || is_active[0] !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_active state=%0d act=%b want=%0d/1", state[0],
                         is_active[0], fc::StAc);
    end
    reset = 1'b1; #1;
    n_checks++;
    if (is_active !== 2'b00 || state_chg !== 2'b00) begin
      n_fail++; $display("FAIL in_reset_flags act=%b chg=%b want 00/00", is_active, state_chg);
    end
    tick();
    n_checks++;
    if (state[0] !== fc::StOl1 || state[1] !== fc::StOl1 || fail_cnt !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset s0=%0d s1=%0d cnt=%h want OL1/OL1/0", state[0],
                         state[1], fail_cnt);
    end
    reset = 1'b0; data = '0; datak = '0;
    tick();
    n_checks++;
    if (state[0] !== fc::StOl1 || is_active !== 2'b00 || state_chg !== 2'b00) begin
      n_fail++; $display("FAIL post_reset s0=%0d act=%b chg=%b want OL1/00/00", state[0],
                         is_active, state_chg);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] words [8];
    logic [15:0] want  [8];
    words[0] = WNos; words[1] = WOls; words[2] = WNos; words[3] = WOls;
    words[4] = WNos; words[5] = WOls;
    want[0] = 16'hFFFE; want[1] = 16'hFFFE; want[2] = 16'hFFFF; want[3] = 16'hFFFF;
    want[4] = 16'hFFFF; want[5] = 16'hFFFF;
    #2;
    force dut.g_lane[0].fail_cnt_q = 16'hFFFD;
    #1;
    release dut.g_lane[0].fail_cnt_q;
    n_checks++;
    if (fail_cnt[15:0] !== 16'hFFFD) begin
      n_fail++; $display("FAIL preset cnt=%h want=FFFD", fail_cnt[15:0]);
    end
    for (int j = 0; j < 6; j++) begin
      drive(0, words[j], KOk); tick();
      n_checks++;
      if (fail_cnt[15:0] !== want[j]) begin
        n_fail++; $display("FAIL saturate step%0d cnt=%h want=%h", j, fail_cnt[15:0], want[j]);
      end
    end
    drive(0, WNos, KOk); cnt_clear[0] = 1'b1; tick();
    n_checks++;
    if (state[0] !== fc::StLf1 || fail_cnt[15:0] !== 16'd0) begin
      n_fail++; $display("FAIL clear_wins state=%0d cnt=%h want=%0d/0000", state[0],
                         fail_cnt[15:0], fc::StLf1);
    end
    cnt_clear[0] = 1'b0; drive(0, WOls, KOk); tick();
    n_checks++;
    if (state[0] !== fc::StOl2 || fail_cnt[15:0] !== 16'd0 || fail_cnt[31:16] !== 16'd0) begin
      n_fail++; $display("FAIL after_clear state=%0d cnt0=%h cnt1=%h want=%0d/0000/0000",
                         state[0], fail_cnt[15:0], fail_cnt[31:16], fc::StOl2);
    end
  endtask

  initial begin
    test_reset();
    test_ols_exit();
    test_active();
    test_los();
    test_online_edge();
    test_bad_k();
    test_mid_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
